// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam logic [31:0] ERR_RDATA       = 32'h0000_0000;

endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin selection: one-hot pick of the requester, favouring
// the master that was not granted last when both ask at once.
module rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    always_comb begin
        pick = 2'b00;
        if (req == 2'b11) begin
            pick = last ? 2'b01 : 2'b10;
        end else begin
            pick = req;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates two masters onto one memory port; one transfer at a time with a
// timeout that completes the transfer with an error flag.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic        mem_req,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  grant
);

    // The counter value seen on the last allowed no-ack ACCESS cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [1:0]  grant_q;
    logic        last_q;
    logic [7:0]  wait_q;
    logic        mem_req_q;
    logic        mem_write_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [1:0]  ack_q;
    logic [1:0]  err_q;
    logic [31:0] m0_rdata_q;
    logic [31:0] m1_rdata_q;

    logic [1:0]  pick_d;
    logic        write_d;
    logic [31:0] addr_d;
    logic [31:0] wdata_d;
    logic [31:0] rdata_d;

    rr_pick u_rr_pick (
        .req  ({m1_req, m0_req}),
        .last (last_q),
        .pick (pick_d)
    );

    assign write_d = pick_d[1] ? m1_write : m0_write;
    assign addr_d  = pick_d[1] ? m1_addr  : m0_addr;
    assign wdata_d = pick_d[1] ? m1_wdata : m0_wdata;
    assign rdata_d = mem_write_q ? 32'h0 : mem_rdata;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= 2'b00;
            last_q      <= 1'b1;
            wait_q      <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            ack_q       <= 2'b00;
            err_q       <= 2'b00;
            m0_rdata_q  <= 32'h0;
            m1_rdata_q  <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_d != 2'b00) begin
                        grant_q     <= pick_d;
                        mem_req_q   <= 1'b1;
                        mem_write_q <= write_d;
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= wdata_d;
                        wait_q      <= 8'd0;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // mem_ack takes priority over an expiring wait counter.
                    if (mem_ack || (wait_q == WAIT_LAST)) begin
                        ack_q       <= grant_q;
                        err_q       <= mem_ack ? 2'b00 : grant_q;
                        m0_rdata_q  <= (grant_q[0] && mem_ack) ? rdata_d : ERR_RDATA;
                        m1_rdata_q  <= (grant_q[1] && mem_ack) ? rdata_d : ERR_RDATA;
                        last_q      <= grant_q[1];
                        mem_req_q   <= 1'b0;
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= 32'h0;
                        mem_wdata_q <= 32'h0;
                        state_q     <= DONE;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                DONE: begin
                    ack_q      <= 2'b00;
                    err_q      <= 2'b00;
                    m0_rdata_q <= 32'h0;
                    m1_rdata_q <= 32'h0;
                    grant_q    <= 2'b00;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign mem_req   = mem_req_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign m0_ack    = ack_q[0];
    assign m1_ack    = ack_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: contention table, directed corner
// sequences and randomized transfers against a transaction-level model.
module tb_bus_arbiter;

    localparam int TMO = 4;

    logic        clock;
    logic        reset;
    logic        m0_req, m1_req, m0_write, m1_write;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic        mem_req, mem_write, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;
    int last_m = 1;

    bus_arbiter #(.TIMEOUT(TMO)) dut (
        .clock     (clock),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_write  (m0_write),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_rdata  (m0_rdata),
        .m0_ack    (m0_ack),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_write  (m1_write),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_rdata  (m1_rdata),
        .m1_ack    (m1_ack),
        .m1_err    (m1_err),
        .mem_req   (mem_req),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .grant     (grant)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic       r0;
        logic       r1;
        logic [1:0] exp_grant;
        int         delay;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_master(input int m, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin
            m0_write = w; m0_addr = a; m0_wdata = d;
        end else begin
            m1_write = w; m1_addr = a; m1_wdata = d;
        end
    endtask

    // One complete transfer: request, optional drop, delay cycles without
    // mem_ack (timeout when delay >= TMO), then the DONE and return-to-IDLE.
    task automatic xfer(input string tag, input logic r0, input logic r1,
                        input logic [1:0] eg, input int delay,
                        input logic [31:0] rd, input logic drop);
        logic        w, ew, to;
        logic [31:0] ea, ewd, erd;
        int          n;
        w   = eg[1];
        ew  = w ? m1_write : m0_write;
        ea  = w ? m1_addr  : m0_addr;
        ewd = w ? m1_wdata : m0_wdata;
        to  = (delay >= TMO);
        erd = (to || ew) ? 32'h0 : rd;
        n   = to ? TMO : delay;

        m0_req = r0; m1_req = r1; mem_ack = 1'b0;
        tick();
        chk({tag, ".grant"},     32'(grant),     32'(eg));
        chk({tag, ".mem_req"},   32'(mem_req),   32'd1);
        chk({tag, ".mem_addr"},  mem_addr,       ea);
        chk({tag, ".mem_write"}, 32'(mem_write), 32'(ew));
        chk({tag, ".mem_wdata"}, mem_wdata,      ewd);
        if (drop) begin
            m0_req = 1'b0; m1_req = 1'b0;
        end
        for (int c = 0; c < n; c++) begin
            mem_rdata = $urandom;
            tick();
            if (c < TMO - 1) begin
                chk({tag, ".wait_mem_req"}, 32'(mem_req), 32'd1);
                chk({tag, ".wait_ack"}, 32'({m1_ack, m0_ack}), 32'd0);
            end
        end
        if (!to) begin
            mem_ack = 1'b1; mem_rdata = rd;
            tick();
            mem_ack = 1'b0; mem_rdata = $urandom;
        end
        chk({tag, ".ack"},      32'({m1_ack, m0_ack}), 32'(eg));
        chk({tag, ".err"},      32'({m1_err, m0_err}), to ? 32'(eg) : 32'd0);
        chk({tag, ".rdata"},    w ? m1_rdata : m0_rdata, erd);
        chk({tag, ".rdata_other"}, w ? m0_rdata : m1_rdata, 32'h0);
        chk({tag, ".done_mem_req"}, 32'(mem_req), 32'd0);
        // Requests and mem_ack in DONE must be ignored.
        m0_req = 1'($urandom); m1_req = 1'($urandom); mem_ack = 1'($urandom);
        tick();
        m0_req = 1'b0; m1_req = 1'b0; mem_ack = 1'b0;
        chk({tag, ".idle_ack"},     32'({m1_ack, m0_ack}), 32'd0);
        chk({tag, ".idle_grant"},   32'(grant),   32'd0);
        chk({tag, ".idle_mem_req"}, 32'(mem_req), 32'd0);
        $display("xfer %s req=%b%b grant=%b delay=%0d timeout=%0d rdata=%h",
                 tag, r1, r0, eg, delay, to, erd);
    endtask

    initial begin
        logic r0, r1;
        logic [1:0] eg;

        reset = 1'b1;
        m0_req = 0; m1_req = 0; m0_write = 0; m1_write = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
        #3;
        chk("reset.grant",   32'(grant),   32'd0);
        chk("reset.mem_req", 32'(mem_req), 32'd0);
        chk("reset.mem_write", 32'(mem_write), 32'd0);
        chk("reset.mem_addr",  mem_addr,  32'd0);
        chk("reset.mem_wdata", mem_wdata, 32'd0);
        chk("reset.ack",   32'({m1_ack, m0_ack}), 32'd0);
        chk("reset.err",   32'({m1_err, m0_err}), 32'd0);
        chk("reset.rdata0", m0_rdata, 32'd0);
        chk("reset.rdata1", m1_rdata, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Round-robin sequence from reset: m0 wins the first contention.
        vecs[0] = '{1'b1, 1'b1, 2'b01, 0};
        vecs[1] = '{1'b1, 1'b1, 2'b10, 1};
        vecs[2] = '{1'b1, 1'b1, 2'b01, 2};
        vecs[3] = '{1'b0, 1'b1, 2'b10, 0};
        vecs[4] = '{1'b0, 1'b1, 2'b10, 1};
        vecs[5] = '{1'b1, 1'b1, 2'b01, 0};
        vecs[6] = '{1'b1, 1'b0, 2'b01, 3};
        vecs[7] = '{1'b1, 1'b0, 2'b01, 0};
        vecs[8] = '{1'b1, 1'b1, 2'b10, 2};
        for (int i = 0; i < 9; i++) begin
            set_master(0, 1'b0, 32'h1000 + 32'(i), 32'hA000_0000 + 32'(i));
            set_master(1, 1'b1, 32'h2000 + 32'(i), 32'hB000_0000 + 32'(i));
            xfer($sformatf("vec%0d", i), vecs[i].r0, vecs[i].r1, vecs[i].exp_grant,
                 vecs[i].delay, 32'h5500_0000 + 32'(i), 1'b0);
        end
        last_m = 1;

        set_master(0, 1'b0, 32'h0000_0100, 32'h0);
        xfer("single_read", 1'b1, 1'b0, 2'b01, 3, 32'hCAFE_F00D, 1'b0);
        last_m = 0;

        set_master(1, 1'b1, 32'h0000_0200, 32'h1234_5678);
        xfer("write_m1", 1'b0, 1'b1, 2'b10, 0, 32'hDEAD_BEEF, 1'b0);
        last_m = 1;

        set_master(0, 1'b0, 32'h0000_0300, 32'h0);
        xfer("timeout_m0", 1'b1, 1'b0, 2'b01, 10, 32'h0BAD_0BAD, 1'b0);
        last_m = 0;

        set_master(1, 1'b0, 32'h0000_0400, 32'h0);
        xfer("req_drop_m1", 1'b0, 1'b1, 2'b10, 2, 32'h7777_1111, 1'b1);
        last_m = 1;

        // Reset two cycles into ACCESS: mem_req falls without a clock edge.
        set_master(0, 1'b0, 32'h0000_0500, 32'h0);
        m0_req = 1'b1;
        tick();
        chk("rst_mid.mem_req_before", 32'(mem_req), 32'd1);
        m0_req = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid.mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid.grant",   32'(grant),   32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        chk("rst_mid.ack", 32'({m1_ack, m0_ack}), 32'd0);
        @(negedge clock);
        reset = 1'b0; mem_ack = 1'b0;
        tick();
        chk("rst_mid.no_ack", 32'({m1_ack, m0_ack}), 32'd0);
        set_master(0, 1'b1, 32'h0000_0600, 32'h6666_6666);
        set_master(1, 1'b0, 32'h0000_0700, 32'h0);
        xfer("after_reset", 1'b1, 1'b1, 2'b01, 1, 32'h0, 1'b0);
        last_m = 0;

        // Randomized transfers against the round-robin rule.
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                m0_req = 1'b0; m1_req = 1'b0; mem_ack = 1'($urandom);
                tick();
                mem_ack = 1'b0;
                chk("rand.idle_grant",   32'(grant),   32'd0);
                chk("rand.idle_mem_req", 32'(mem_req), 32'd0);
                chk("rand.idle_ack", 32'({m1_ack, m0_ack}), 32'd0);
            end
            do begin
                r0 = 1'($urandom);
                r1 = 1'($urandom);
            end while (!r0 && !r1);
            if (r0 && r1) eg = (last_m == 1) ? 2'b01 : 2'b10;
            else          eg = r0 ? 2'b01 : 2'b10;
            set_master(0, 1'($urandom), $urandom, $urandom);
            set_master(1, 1'($urandom), $urandom, $urandom);
            xfer($sformatf("rand%0d", t), r0, r1, eg, $urandom_range(0, 6),
                 $urandom, ($urandom_range(0, 3) == 0));
            last_m = eg[1] ? 1 : 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of ACCESS-state cycles without mem_ack before the arbiter aborts the transaction.
REQ-002 SHALL have port clock, input, 1 bit: system clock, rising edge active.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports m0_req/m1_req, input, 1 bit each: master requests a transfer.
REQ-005 SHALL have ports m0_write/m1_write, input, 1 bit each: 1 = write, 0 = read.
REQ-006 SHALL have ports m0_addr/m1_addr and m0_wdata/m1_wdata, input, 32 bits each: address and write data.
REQ-007 SHALL have ports m0_rdata/m1_rdata, output, 32 bits each: read data, valid while the matching ack is high.
REQ-008 SHALL have ports m0_ack/m1_ack and m0_err/m1_err, output, 1 bit each: transfer done, and done-by-timeout.
REQ-009 SHALL have ports mem_req, mem_write (output, 1 bit), mem_addr and mem_wdata (output, 32 bits): shared memory port.
REQ-010 SHALL have ports mem_rdata (input, 32 bits) and mem_ack (input, 1 bit): memory response.
REQ-011 SHALL have port grant, output, 2 bits: one-hot owner of the current transfer; 00 when idle.

Function
REQ-012 SHALL implement the FSM states IDLE, ACCESS and DONE.
REQ-013 In IDLE, if any mX_req is sampled high at a rising edge, SHALL latch that master's write/addr/wdata, set grant, and enter ACCESS.
REQ-014 When both requests are high in IDLE, SHALL grant the master not granted last (round-robin); with a single request, SHALL grant that master regardless of history.
REQ-015 In ACCESS, SHALL drive mem_req=1 and the latched mem_write, mem_addr and mem_wdata from registers, held stable until exit.
REQ-016 In ACCESS, on mem_ack sampled high, SHALL capture mem_rdata (reads only; writes return 0), enter DONE, and update the last-granted master.
REQ-017 In DONE, SHALL drive only the granted master's mX_ack=1 and mX_rdata for exactly one cycle, drive mem_req=0, then return to IDLE.
REQ-018 Requests SHALL NOT be sampled in ACCESS or DONE.
REQ-019 A master deasserting req during ACCESS SHALL NOT abort the transfer; the transfer SHALL complete and be acknowledged.
REQ-020 Masters SHALL deassert req during the ack cycle unless issuing a new transfer; req high in IDLE SHALL always be treated as a new request.
REQ-021 An 8-bit wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without mem_ack.
REQ-022 When the wait counter reaches TIMEOUT, SHALL drive mem_req=0, enter DONE with rdata=32'h0000_0000, and assert mX_err together with mX_ack.
REQ-023 If mem_ack and timeout coincide, mem_ack SHALL win (err=0).
REQ-024 mem_ack SHALL be ignored outside ACCESS.
REQ-025 Latency SHALL be: req sampled at edge N, mem_req high after edge N; mem_ack sampled at edge M, mX_ack high from edge M to edge M+1; minimum request-to-ack is 2 cycles.
REQ-026 Minimum spacing between back-to-back transfers SHALL be 3 cycles (IDLE, ACCESS, DONE).

Reset
REQ-027 On reset assertion, SHALL asynchronously enter IDLE and drive mem_req, mem_write, mem_addr, mem_wdata, grant, both ack, both err and both rdata to 0.
REQ-028 On reset, the last-granted master SHALL be m1, so m0 wins the first contention.
REQ-029 Reset during ACCESS SHALL drop mem_req immediately, discard the in-flight result, and issue no ack.

Structure
REQ-030 A shared package bus_pkg SHALL hold the state enum (IDLE, ACCESS, DONE), the TIMEOUT default, and the error rdata constant.
REQ-031 The two-way round-robin selection SHALL be a combinational sub-module rr_pick (inputs req[1:0] and last; output one-hot pick).

Verification
REQ-032 Single read: m0 read of addr 0x100, mem_ack 3 cycles later with rdata 0xCAFE_F00D -> m0_ack and m0_rdata=0xCAFE_F00D for one cycle; m1_ack stays 0.
REQ-033 Contention: m0 and m1 request together from reset -> m0 served first; m1 held and served next; a third contention grants m0.
REQ-034 Write: m1 write of 0x1234_5678 to 0x200, mem_ack in the same cycle as ACCESS entry -> mem_wdata=0x1234_5678 and mem_write=1 while mem_req is high; m1_ack exactly 2 cycles after req.
REQ-035 Timeout: TIMEOUT=4, mem_ack never asserted -> mem_req high 4 cycles, then m0_ack=1, m0_err=1, m0_rdata=0.
REQ-036 Reset mid-transfer: reset asserted 2 cycles into ACCESS -> mem_req=0 without waiting for a clock edge, no ack, next request granted normally.
REQ-037 Req drop: m1 deasserts req during ACCESS, mem_ack arrives later -> m1_ack still pulses once.
